// File: rtl/result_nibble_reader_pkg.sv
// Shared types and constants for the result nibble reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_nibble_reader_pkg;

  // Width of one displayed nibble (one LED per bit)
  localparam int NIB_W = 4;

  // Display FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/result_nibble_reader_pb_debounce.sv
// Raw pushbutton conditioner: synchroniser, debounce counter, press pulse.
// Latency: raw edge -> pulse = 2 + DEB_CYCLES cycles.
// Backpressure: none; a glitch shorter than DEB_CYCLES cycles is discarded.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   pb_raw  raw, bouncy, asynchronous button level
//   pulse   one-cycle strobe when the debounced level rises 0->1
module pb_debounce
  import result_nibble_reader_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // Stable level flips on the DEB_CYCLES-th consecutive disagreement.
  logic w_flip;
  assign w_flip = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= pb_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Only the press (0->1) produces a strobe; release is silent.
      r_pulse <= w_flip && r_sync2;
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/result_nibble_reader.sv
// Captures {cout,sum} on a load press and shows it one nibble per next press.
// Latency: outputs update one cycle after a debounced press pulse.
// Backpressure: none; presses in states that ignore them are dropped.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sum, cout        adder result to capture
//   pb_load, pb_next raw pushbuttons (capture / advance)
//   led              displayed nibble (0 when nothing shown)
//   nib_idx          index of displayed nibble, 0 = least significant
//   showing          a nibble is on the LEDs
//   done             last nibble has been stepped past; held until next load
module result_nibble_reader
  import result_nibble_reader_pkg::*;
#(
  parameter int DATA_W     = 7,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sum,
  input  logic              cout,
  input  logic              pb_load,
  input  logic              pb_next,
  output logic [NIB_W-1:0]  led,
  output logic [1:0]        nib_idx,
  output logic              showing,
  output logic              done
);

  localparam int NIB_N    = (DATA_W + 1 + NIB_W - 1) / NIB_W;
  localparam int SHADOW_W = NIB_N * NIB_W;
  localparam logic [1:0] LAST_IDX = 2'(NIB_N - 1);

  logic w_load_p;
  logic w_next_p;

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk    (clk),
    .rst    (rst),
    .pb_raw (pb_load),
    .pulse  (w_load_p)
  );

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk    (clk),
    .rst    (rst),
    .pb_raw (pb_next),
    .pulse  (w_next_p)
  );

  state_t              r_state;
  logic [SHADOW_W-1:0] r_shadow;
  logic [1:0]          r_idx;
  logic [NIB_W-1:0]    r_led;
  logic                r_showing;
  logic                r_done;

  state_t              w_state_nxt;
  logic [SHADOW_W-1:0] w_shadow_nxt;
  logic [1:0]          w_idx_nxt;
  logic [NIB_W-1:0]    w_led_nxt;
  logic                w_showing_nxt;
  logic                w_done_nxt;

  // Result zero-extended to whole nibbles; padding bits are always 0.
  logic [SHADOW_W-1:0] w_capture;
  assign w_capture = SHADOW_W'({cout, sum});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_idx     <= '0;
      r_led     <= '0;
      r_showing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shadow  <= w_shadow_nxt;
      r_idx     <= w_idx_nxt;
      r_led     <= w_led_nxt;
      r_showing <= w_showing_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_idx_nxt     = r_idx;
    w_led_nxt     = '0;
    w_showing_nxt = 1'b0;
    w_done_nxt    = 1'b0;

    // Load has priority over next in every state; a coincident next is dropped.
    if (w_load_p) begin
      w_shadow_nxt = w_capture;
      w_idx_nxt    = '0;
      w_state_nxt  = ST_SHOW;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_SHOW: begin
          if (w_next_p) begin
            if (r_idx == LAST_IDX) begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_DONE;
            end else begin
              w_idx_nxt = r_idx + 2'd1;
            end
          end
        end
        ST_DONE: ;
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    unique case (w_state_nxt)
      ST_SHOW: begin
        w_led_nxt     = w_shadow_nxt[NIB_W*int'(w_idx_nxt) +: NIB_W];
        w_showing_nxt = 1'b1;
      end
      ST_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign led     = r_led;
  assign nib_idx = r_idx;
  assign showing = r_showing;
  assign done    = r_done;

endmodule

// File: tb/tb_result_nibble_reader.sv
// Directed bench for result_nibble_reader with a short debounce window.
module tb_result_nibble_reader;

  localparam int DATA_W = 7;
  localparam int DEB    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sum = '0;
  logic              cout = 1'b0;
  logic              pb_load = 1'b0;
  logic              pb_next = 1'b0;
  logic [3:0]        led;
  logic [1:0]        nib_idx;
  logic              showing;
  logic              done;

  int n_chk  = 0;
  int n_pass = 0;

  result_nibble_reader #(.DATA_W(DATA_W), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .sum     (sum),
    .cout    (cout),
    .pb_load (pb_load),
    .pb_next (pb_next),
    .led     (led),
    .nib_idx (nib_idx),
    .showing (showing),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the selected raw buttons for `hold` cycles, release, and let the
  // debouncers settle back to 0 before returning.
  task automatic press(input bit ld, input bit nx, input int hold);
    pb_load = ld;
    pb_next = nx;
    cyc(hold);
    pb_load = 1'b0;
    pb_next = 1'b0;
    cyc(12);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_led, input logic [1:0] e_idx,
                         input logic e_show, input logic e_done);
    chk({tag, ".led"},     {4'h0, led},     {4'h0, e_led});
    chk({tag, ".idx"},     {6'h0, nib_idx}, {6'h0, e_idx});
    chk({tag, ".showing"}, {7'h0, showing}, {7'h0, e_show});
    chk({tag, ".done"},    {7'h0, done},    {7'h0, e_done});
  endtask

  initial begin
    cyc(3);
    chk_all("reset", 4'h0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(2);
    chk_all("idle", 4'h0, 2'd0, 1'b0, 1'b0);

    // next in IDLE is ignored
    press(1'b0, 1'b1, 6);
    chk_all("idle_next", 4'h0, 2'd0, 1'b0, 1'b0);

    // capture 0xDA, show LS nibble
    sum = 7'h5A; cout = 1'b1;
    press(1'b1, 1'b0, 6);
    chk_all("load_DA", 4'hA, 2'd0, 1'b1, 1'b0);

    press(1'b0, 1'b1, 6);
    chk_all("next1", 4'hD, 2'd1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 6);
    chk_all("next_done", 4'h0, 2'd0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 6);
    chk_all("done_hold", 4'h0, 2'd0, 1'b0, 1'b1);

    // reload from DONE
    press(1'b1, 1'b0, 6);
    chk_all("reload", 4'hA, 2'd0, 1'b1, 1'b0);

    // 3-cycle glitch is rejected
    press(1'b0, 1'b1, 3);
    chk_all("glitch", 4'hA, 2'd0, 1'b1, 1'b0);

    // 4-cycle press: pulse after 2+4 edges, outputs one edge later
    pb_next = 1'b1;
    cyc(4);
    pb_next = 1'b0;
    cyc(2);
    chk("lat6.led", {4'h0, led}, 8'h0A);
    cyc(1);
    chk("lat7.led", {4'h0, led}, 8'h0D);
    chk("lat7.idx", {6'h0, nib_idx}, 8'h01);
    cyc(12);

    // shadow is not live
    sum = 7'h01; cout = 1'b0;
    cyc(3);
    chk("hold_shadow.led", {4'h0, led}, 8'h0D);

    press(1'b1, 1'b0, 6);
    chk_all("load_01", 4'h1, 2'd0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 6);
    chk_all("pad_nib", 4'h0, 2'd1, 1'b1, 1'b0);

    // load and next together at nib_idx=1: load wins
    sum = 7'h23; cout = 1'b0;
    press(1'b1, 1'b1, 6);
    chk_all("both", 4'h3, 2'd0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 6);
    chk_all("both_next", 4'h2, 2'd1, 1'b1, 1'b0);

    // async reset mid-SHOW with led=D
    sum = 7'h5A; cout = 1'b1;
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    chk("pre_rst.led", {4'h0, led}, 8'h0D);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'h0, 2'd0, 1'b0, 1'b0);

    // load held through reset release: no pulse until the count completes
    sum = 7'h34; cout = 1'b0;
    pb_load = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("held_early.showing", {7'h0, showing}, 8'h00);
    cyc(1);
    chk("held_late.showing", {7'h0, showing}, 8'h01);
    chk("held_late.led", {4'h0, led}, 8'h04);
    pb_load = 1'b0;
    cyc(12);
    chk_all("held_settle", 4'h4, 2'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
